// File: rtl/riscv_multicycle_ctrl.sv
// Multicycle RV32I control unit: sequences the shared memory port, ALU and register file.
// state    | meaning
// FETCH    | read instruction at PC, PC <= PC+4
// DECODE   | ALUOut <= OldPC + imm (branch/jal target)
// MEMADR   | compute rs1 + imm for lw/sw
// MEMREAD  | read data memory at ALUOut
// MEMWB    | rd <= loaded data
// MEMWRITE | store rs2 at ALUOut
// EXEC_R   | rs1 op rs2
// EXEC_I   | rs1 op imm
// ALUWB    | rd <= ALUOut
// BRANCH   | compare, PC <= target if taken
// JAL      | PC <= target, ALUOut <= OldPC+4
// LUI      | imm << 12
// HALT     | unsupported opcode, parked until reset
module riscv_multicycle_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       BranchYN,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ImmSrc,
    output logic       RegWrite,
    output logic [3:0] ALUControl,
    output logic       Retire,
    output logic       Halted
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_LUI      = 4'd11,
        S_HALT     = 4'd12
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_LUI = 4'b1110;

    state_t state_q, state_d;

    logic       pc_write_s, mem_write_s, ir_write_s, reg_write_s, retire_s;
    logic [3:0] funct_alu;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // Only R-type may subtract on funct3=000; shifts honour funct7b5 for both forms.
    always_comb begin
        funct_alu = ALU_ADD;
        case (funct3)
            3'b000:  funct_alu = (op == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  funct_alu = 4'b0110;
            3'b010:  funct_alu = 4'b0101;
            3'b100:  funct_alu = 4'b0100;
            3'b101:  funct_alu = funct7b5 ? 4'b1111 : 4'b0111;
            3'b110:  funct_alu = 4'b0011;
            3'b111:  funct_alu = 4'b0010;
            default: funct_alu = ALU_ADD;
        endcase
    end

    always_comb begin
        case (op)
            OP_SW:   ImmSrc = 3'b001;
            OP_BR:   ImmSrc = 3'b010;
            OP_JAL:  ImmSrc = 3'b011;
            OP_LUI:  ImmSrc = 3'b100;
            default: ImmSrc = 3'b000;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        pc_write_s  = 1'b0;
        AdrSrc      = 1'b0;
        mem_write_s = 1'b0;
        ir_write_s  = 1'b0;
        ResultSrc   = 2'b00;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        reg_write_s = 1'b0;
        ALUControl  = ALU_ADD;
        retire_s    = 1'b0;
        Halted      = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_write_s = 1'b1;
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
                pc_write_s = 1'b1;
                state_d    = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXEC_R;
                    OP_I:         state_d = S_EXEC_I;
                    OP_BR:        state_d = S_BRANCH;
                    OP_JAL:       state_d = S_JAL;
                    OP_LUI:       state_d = S_LUI;
                    default:      state_d = S_HALT;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc  = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc   = 2'b01;
                reg_write_s = 1'b1;
                retire_s    = 1'b1;
                state_d     = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc      = 1'b1;
                mem_write_s = 1'b1;
                retire_s    = 1'b1;
                state_d     = S_FETCH;
            end
            S_EXEC_R: begin
                ALUSrcA    = 2'b10;
                ALUControl = funct_alu;
                state_d    = S_ALUWB;
            end
            S_EXEC_I: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = funct_alu;
                state_d    = S_ALUWB;
            end
            S_LUI: begin
                ALUSrcB    = 2'b01;
                ALUControl = ALU_LUI;
                state_d    = S_ALUWB;
            end
            S_JAL: begin
                ALUSrcA    = 2'b01;
                ALUSrcB    = 2'b10;
                pc_write_s = 1'b1;
                state_d    = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_s = 1'b1;
                retire_s    = 1'b1;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = 2'b10;
                ALUControl = ALU_SUB;
                pc_write_s = BranchYN;
                retire_s   = 1'b1;
                state_d    = S_FETCH;
            end
            S_HALT: begin
                Halted  = 1'b1;
                state_d = S_HALT;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // State is already FETCH during reset; only the enables need masking.
    assign PCWrite  = pc_write_s  & reset;
    assign MemWrite = mem_write_s & reset;
    assign IRWrite  = ir_write_s  & reset;
    assign RegWrite = reg_write_s & reset;
    assign Retire   = retire_s    & reset;

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Scoreboard bench for riscv_multicycle_ctrl: expected per-cycle output traces are queued
// per instruction and checked by a monitor each time the DUT pulses Retire.
module tb_riscv_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       BranchYN;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Retire, Halted;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ImmSrc;
    logic [3:0] ALUControl;

    riscv_multicycle_ctrl dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .BranchYN(BranchYN), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ImmSrc(ImmSrc), .RegWrite(RegWrite), .ALUControl(ALUControl), .Retire(Retire),
        .Halted(Halted)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       name;
        int          n;
        logic [19:0] v [5];
    } exp_t;

    exp_t        exp_q [$];
    logic [19:0] tr [$];
    logic [19:0] obs;

    assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                  ImmSrc, RegWrite, ALUControl, Retire, Halted};

    function automatic logic [19:0] ev(logic pcw, logic adr, logic mw, logic irw,
                                       logic [1:0] rs, logic [1:0] sa, logic [1:0] sb,
                                       logic [2:0] imm, logic rw, logic [3:0] alu, logic ret);
        return {pcw, adr, mw, irw, rs, sa, sb, imm, rw, alu, ret, 1'b0};
    endfunction

    // Hand-written per-state expectations.
    function automatic logic [19:0] s_fetch(logic [2:0] i);    return ev(1,0,0,1,2'b10,2'b00,2'b10,i,0,4'b0000,0); endfunction
    function automatic logic [19:0] s_decode(logic [2:0] i);   return ev(0,0,0,0,2'b00,2'b01,2'b01,i,0,4'b0000,0); endfunction
    function automatic logic [19:0] s_memadr(logic [2:0] i);   return ev(0,0,0,0,2'b00,2'b10,2'b01,i,0,4'b0000,0); endfunction
    function automatic logic [19:0] s_memread(logic [2:0] i);  return ev(0,1,0,0,2'b00,2'b00,2'b00,i,0,4'b0000,0); endfunction
    function automatic logic [19:0] s_memwb(logic [2:0] i);    return ev(0,0,0,0,2'b01,2'b00,2'b00,i,1,4'b0000,1); endfunction
    function automatic logic [19:0] s_memwrite(logic [2:0] i); return ev(0,1,1,0,2'b00,2'b00,2'b00,i,0,4'b0000,1); endfunction
    function automatic logic [19:0] s_exr(logic [2:0] i, logic [3:0] a); return ev(0,0,0,0,2'b00,2'b10,2'b00,i,0,a,0); endfunction
    function automatic logic [19:0] s_exi(logic [2:0] i, logic [3:0] a); return ev(0,0,0,0,2'b00,2'b10,2'b01,i,0,a,0); endfunction
    function automatic logic [19:0] s_lui(logic [2:0] i);      return ev(0,0,0,0,2'b00,2'b00,2'b01,i,0,4'b1110,0); endfunction
    function automatic logic [19:0] s_jal(logic [2:0] i);      return ev(1,0,0,0,2'b00,2'b01,2'b10,i,0,4'b0000,0); endfunction
    function automatic logic [19:0] s_aluwb(logic [2:0] i);    return ev(0,0,0,0,2'b00,2'b00,2'b00,i,1,4'b0000,1); endfunction
    function automatic logic [19:0] s_branch(logic [2:0] i, logic t); return ev(t,0,0,0,2'b00,2'b10,2'b00,i,0,4'b0001,1); endfunction

    function automatic exp_t mk(string nm, int n, logic [19:0] a, logic [19:0] b,
                                logic [19:0] c, logic [19:0] d, logic [19:0] e);
        exp_t x;
        x.name = nm; x.n = n;
        x.v[0] = a; x.v[1] = b; x.v[2] = c; x.v[3] = d; x.v[4] = e;
        return x;
    endfunction

    function automatic exp_t r_instr(string nm, logic [3:0] alu);
        return mk(nm, 4, s_fetch(3'b000), s_decode(3'b000), s_exr(3'b000, alu), s_aluwb(3'b000), 20'h0);
    endfunction

    function automatic exp_t i_instr(string nm, logic [3:0] alu);
        return mk(nm, 4, s_fetch(3'b000), s_decode(3'b000), s_exi(3'b000, alu), s_aluwb(3'b000), 20'h0);
    endfunction

    // Monitor: accumulate the trace since the last retire and score it on each Retire.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            tr.delete();
        end else begin
            tr.push_back(obs);
            if (Retire) begin
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_retire: Retire=1 with no instruction outstanding, outputs=%h", obs);
                end else begin
                    e = exp_q.pop_front();
                    n_tests++;
                    if (tr.size() != e.n) begin
                        n_fail++;
                        $display("FAIL %s cycles: got %0d, expected %0d", e.name, tr.size(), e.n);
                    end
                    for (int i = 0; i < e.n && i < tr.size(); i++) begin
                        n_tests++;
                        if (tr[i] !== e.v[i]) begin
                            n_fail++;
                            $display("FAIL %s cycle%0d: got %b, expected %b", e.name, i + 1, tr[i], e.v[i]);
                        end
                    end
                end
                tr.delete();
            end
            if (tr.size() > 8) tr.delete();
        end
    end

    task automatic check(string nm, logic ok, logic [19:0] got);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: outputs %b", nm, got);
        end
    endtask

    // Called just after the rising edge that enters FETCH.
    task automatic run_instr(logic [6:0] o, logic [2:0] f3, logic f7, logic byn, exp_t e);
        bit done = 0;
        op = o; funct3 = f3; funct7b5 = f7; BranchYN = byn;
        exp_q.push_back(e);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (Retire) begin done = 1; break; end
        end
        if (!done) begin
            n_tests++; n_fail++;
            $display("FAIL %s timeout: no Retire within 10 cycles, got 0 expected 1", e.name);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0; BranchYN = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("reset_hold", {PCWrite, IRWrite, RegWrite, MemWrite, Retire} == 5'b0 &&
                  ALUSrcB == 2'b10 && ResultSrc == 2'b10 && AdrSrc == 1'b0 && Halted == 1'b0, obs);
        end
        @(posedge clk); #1;
        reset = 1'b1;

        run_instr(7'b0000011, 3'b010, 1'b0, 1'b0,
                  mk("lw", 5, s_fetch(3'b000), s_decode(3'b000), s_memadr(3'b000),
                     s_memread(3'b000), s_memwb(3'b000)));
        run_instr(7'b0100011, 3'b010, 1'b0, 1'b0,
                  mk("sw", 4, s_fetch(3'b001), s_decode(3'b001), s_memadr(3'b001),
                     s_memwrite(3'b001), 20'h0));
        run_instr(7'b0110011, 3'b000, 1'b1, 1'b0, r_instr("r_sub", 4'b0001));
        run_instr(7'b0010011, 3'b000, 1'b1, 1'b0, i_instr("i_addi_f7", 4'b0000));
        run_instr(7'b0010011, 3'b101, 1'b1, 1'b0, i_instr("i_srai", 4'b1111));
        run_instr(7'b0110011, 3'b101, 1'b0, 1'b0, r_instr("r_srl", 4'b0111));
        run_instr(7'b0110011, 3'b011, 1'b0, 1'b0, r_instr("r_sltu", 4'b0000));
        run_instr(7'b0110011, 3'b001, 1'b0, 1'b0, r_instr("r_sll", 4'b0110));
        run_instr(7'b0010011, 3'b010, 1'b0, 1'b0, i_instr("i_slti", 4'b0101));
        run_instr(7'b0110011, 3'b100, 1'b0, 1'b0, r_instr("r_xor", 4'b0100));
        run_instr(7'b0110011, 3'b110, 1'b0, 1'b0, r_instr("r_or", 4'b0011));
        run_instr(7'b0010011, 3'b111, 1'b0, 1'b0, i_instr("i_andi", 4'b0010));
        run_instr(7'b0110111, 3'b000, 1'b0, 1'b0,
                  mk("lui", 4, s_fetch(3'b100), s_decode(3'b100), s_lui(3'b100), s_aluwb(3'b100), 20'h0));
        run_instr(7'b1100011, 3'b000, 1'b0, 1'b1,
                  mk("beq_taken", 3, s_fetch(3'b010), s_decode(3'b010), s_branch(3'b010, 1'b1), 20'h0, 20'h0));
        run_instr(7'b1100011, 3'b001, 1'b0, 1'b0,
                  mk("bne_not_taken", 3, s_fetch(3'b010), s_decode(3'b010), s_branch(3'b010, 1'b0), 20'h0, 20'h0));
        run_instr(7'b1101111, 3'b000, 1'b0, 1'b0,
                  mk("jal", 4, s_fetch(3'b011), s_decode(3'b011), s_jal(3'b011), s_aluwb(3'b011), 20'h0));

        // Illegal opcode parks in HALT.
        op = 7'b1110011; funct3 = 3'b000; funct7b5 = 1'b0; BranchYN = 1'b0;
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("halt_hold", Halted == 1'b1 &&
                  {PCWrite, IRWrite, MemWrite, RegWrite, Retire} == 5'b0, obs);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("halt_reset", Halted == 1'b0 && IRWrite == 1'b0 && ALUSrcB == 2'b10 &&
              ResultSrc == 2'b10, obs);

        // lw abandoned by reset in MEMREAD.
        @(posedge clk); #1;
        reset = 1'b1; op = 7'b0000011; funct3 = 3'b010;
        for (int k = 0; k < 4; k++) @(negedge clk);
        check("memread_reached", AdrSrc == 1'b1 && ResultSrc == 2'b00 && RegWrite == 1'b0, obs);
        #1 reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("abandoned_lw", {RegWrite, MemWrite, Retire, PCWrite, IRWrite} == 5'b0 &&
                  ALUSrcB == 2'b10, obs);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        run_instr(7'b0110111, 3'b000, 1'b0, 1'b0,
                  mk("lui_after_reset", 4, s_fetch(3'b100), s_decode(3'b100), s_lui(3'b100),
                     s_aluwb(3'b100), 20'h0));

        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d instructions outstanding, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/riscv_multicycle_ctrl.md
# riscv_multicycle_ctrl

Multicycle control unit for the RV32I datapath. It sequences one shared memory port, one ALU and the register file over 3–5 clocks per instruction, replacing the single-cycle `controller`. It sits between the instruction register (`op`/`funct3`/`funct7b5` fields) and the multicycle datapath muxes and enables. The instruction set is the one the single-cycle core already runs: lw, sw, R-type, I-type ALU, all six branches, jal and lui.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- op  in  7  opcode, from the instruction register
- funct3  in  3  funct3, from the instruction register
- funct7b5  in  1  instruction bit 30
- BranchYN  in  1  branch comparator result (taken = 1)
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address select: 0 = PC, 1 = Result
- MemWrite  out  1  memory write enable
- IRWrite  out  1  enable for the instruction register and the OldPC register
- ResultSrc  out  2  00 = ALUOut, 01 = Data register, 10 = ALUResult
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = rs1 register
- ALUSrcB  out  2  00 = rs2 register, 01 = ImmExt, 10 = constant 4
- ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U
- RegWrite  out  1  register file write enable
- ALUControl  out  4  0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sll, 0111 srl, 1111 sra, 1110 lui (b<<12)
- Retire  out  1  one-cycle pulse in the last cycle of each instruction
- Halted  out  1  high in HALT

## Operation
- Moore FSM with a 4-bit state register. Exceptions to pure Moore outputs:
  - PCWrite in BRANCH is BranchYN.
  - ALUControl in EXEC_R/EXEC_I depends on funct3/funct7b5.
  - ImmSrc is decoded from op in every state.
- States and outputs (any output not listed is 0, except ImmSrc):
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUControl=add, ResultSrc=10, PCWrite=1. Next: DECODE.
  - DECODE: ALUSrcA=01, ALUSrcB=01, add. This precomputes the branch/jal target into ALUOut. Next state by op:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXEC_R
    - 0010011 → EXEC_I
    - 1100011 → BRANCH
    - 1101111 → JAL
    - 0110111 → LUI
    - any other opcode → HALT
  - MEMADR: ALUSrcA=10, ALUSrcB=01, add. Next: MEMREAD if op=0000011, else MEMWRITE.
  - MEMREAD: ResultSrc=00, AdrSrc=1. Next: MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1, Retire=1. Next: FETCH.
  - MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1, Retire=1. Next: FETCH.
  - EXEC_R: ALUSrcA=10, ALUSrcB=00, funct decode. Next: ALUWB.
  - EXEC_I: ALUSrcA=10, ALUSrcB=01, funct decode. Next: ALUWB.
  - LUI: ALUSrcB=01, ALUControl=1110. Next: ALUWB.
  - JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1. Next: ALUWB (rd ← OldPC+4).
  - ALUWB: ResultSrc=00, RegWrite=1, Retire=1. Next: FETCH.
  - BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, PCWrite=BranchYN, Retire=1. Next: FETCH.
  - HALT: Halted=1, all enables 0. Stays in HALT until reset.
- Funct decode (EXEC_R/EXEC_I):
  - funct3 000: sub if (R-type and funct7b5), else add. addi never subtracts.
  - 001 sll, 010 slt, 100 xor, 110 or, 111 and.
  - 101: sra if funct7b5, else srl. Applies to both R-type and I-type.
  - funct3 011 (sltu/sltiu) is unsupported → ALUControl=0000; the instruction still writes back.
- ImmSrc by op: lw/I-type 000, sw 001, branch 010, jal 011, lui 100. Any other op → 000.
- Branch funct3 010/011 (BranchYN is x) is not defined behaviour; the bench does not drive it.

## Timing
- Cycles per instruction: lw 5, sw 4, R-type 4, I-type 4, lui 4, jal 4, branch 3 (taken or not).
- Reset:
  - reset low forces state=FETCH asynchronously.
  - While reset is low, PCWrite, IRWrite, MemWrite, RegWrite and Retire are forced to 0 combinationally. All other outputs take their FETCH values.
  - The first FETCH cycle is the first rising edge with reset high.
- Reset asserted mid-instruction: the instruction is abandoned, with no RegWrite/MemWrite after reset falls. A write already committed on an earlier edge stands.
- HALT is left only through reset.
- op/funct inputs are used only from DECODE onward; in FETCH they reflect the previous instruction and are ignored.
- Retire is high for exactly one cycle per completed instruction, never in HALT or during reset.

## Test plan
- **Reset:** hold reset low 3 cycles with op=0110011 → state FETCH; PCWrite=IRWrite=RegWrite=MemWrite=0. Release → FETCH outputs on the next cycle (IRWrite=1, ALUSrcB=10, ResultSrc=10).
- **lw then sw:** op=0000011 → exactly 5 cycles; RegWrite only in cycle 5 with ResultSrc=01. op=0100011 → 4 cycles; MemWrite=1 only in cycle 4, AdrSrc=1.
- **ALU decode:**
  - R-type funct3=000, funct7b5=1 → ALUControl=0001.
  - I-type funct3=000, funct7b5=1 → 0000.
  - I-type funct3=101, funct7b5=1 → 1111.
  - lui → 1110 with ImmSrc=100.
- **Branch:** op=1100011 with BranchYN=1 → PCWrite=1 in cycle 3, Retire=1, back to FETCH. With BranchYN=0 → PCWrite=0 in cycle 3.
- **jal:** 4 cycles; PCWrite=1 in cycle 1 and cycle 3; RegWrite=1 in cycle 4 with ResultSrc=00.
- **Illegal op and mid-instruction reset:**
  - op=1110011 → HALT after DECODE; Halted=1, enables 0 for 20 cycles. Reset low → FETCH.
  - Reset low in MEMREAD of a lw → no RegWrite pulse ever appears for that lw.
